serial_frame_rx: RTL and testbench

- Downstream consumer of the 10-bit serial shift-register stage.
- Takes its 1-bit serial output plus the same enable qualifier, delimits frames, deserialises data bits LSB-first and checks optional parity and the stop bit.
- Holds each good word in an output register with a valid/ack handshake for the parallel-side logic.
- Line idles at 0, which is the upstream reset/disable level. Start bit = 1, stop bit = 0.

---
 rtl/serial_frame_rx.sv | 133 +++++++++++++
 tb/tb_serial_frame_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: delimits start/data/parity/stop frames on a qualified
// serial line and presents each good word through a valid/ack output register.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_en,
  input  logic              ser_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ack,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W < 2) ? 1 : $clog2(DATA_W);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;
  logic              ovr_q, ovr_d;
  logic              parity_bad;
  logic              last_bit;

  // Even parity: data bits XOR parity bit must be zero.
  assign parity_bad = PARITY_EN && ((^buf_q) ^ par_q);
  assign last_bit   = (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && data_ack) begin
      valid_d = 1'b0;
    end

    if (ser_en) begin
      case (state_q)
        S_IDLE: begin
          if (ser_in) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) buf_d[i] = ser_in;
          end
          if (last_bit) begin
            cnt_d   = '0;
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          par_d   = ser_in;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          ferr_d  = ser_in;
          perr_d  = parity_bad;
          if (!ser_in && !parity_bad) begin
            // An ack on this same edge frees the register for the new word.
            if (!valid_q || data_ack) begin
              data_d  = buf_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: one instance without parity, one with parity,
// driven by directed and random frames against a frame-level reference model.
module tb_serial_frame_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       en0 = 1'b0, in0 = 1'b0, ack0 = 1'b0;
  logic [7:0] dout0;
  logic       dv0, ferr0, perr0, ovr0, busy0;

  logic       en1 = 1'b0, in1 = 1'b0, ack1 = 1'b0;
  logic [7:0] dout1;
  logic       dv1, ferr1, perr1, ovr1, busy1;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_out[2];
  logic       exp_valid[2];

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b0)) u_np (
    .clk(clk), .rst_n(rst_n), .ser_en(en0), .ser_in(in0),
    .data_out(dout0), .data_valid(dv0), .data_ack(ack0),
    .frame_err(ferr0), .parity_err(perr0), .overrun(ovr0), .busy(busy0)
  );

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) u_par (
    .clk(clk), .rst_n(rst_n), .ser_en(en1), .ser_in(in1),
    .data_out(dout1), .data_valid(dv1), .data_ack(ack1),
    .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] g_out(int p);  return p ? dout1 : dout0; endfunction
  function automatic logic g_valid(int p);      return p ? dv1   : dv0;   endfunction
  function automatic logic g_ferr(int p);       return p ? ferr1 : ferr0; endfunction
  function automatic logic g_perr(int p);       return p ? perr1 : perr0; endfunction
  function automatic logic g_ovr(int p);        return p ? ovr1  : ovr0;  endfunction
  function automatic logic g_busy(int p);       return p ? busy1 : busy0; endfunction

  task automatic set_in(input int p, input logic e, input logic s, input logic a);
    en0 = 1'b0; ack0 = 1'b0; en1 = 1'b0; ack1 = 1'b0;
    if (p == 0) begin en0 = e; in0 = s; ack0 = a; end
    else        begin en1 = e; in1 = s; ack1 = a; end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic cycle(input int p, input logic e, input logic s, input logic a);
    @(negedge clk);
    set_in(p, e, s, a);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input int p, input string tag);
    chk({tag, ".valid"}, g_valid(p), exp_valid[p]);
    chk({tag, ".data"},  g_out(p),   exp_out[p]);
  endtask

  // Sends a whole frame; the model decides the frame's fate from the word,
  // parity bit and stop bit, then updates the expected output register.
  task automatic send_frame(input int p, input logic [7:0] w, input logic par_bit,
                            input logic stop_bit, input int gap, input logic ack_stop,
                            input logic post_idle);
    logic bits[$];
    logic f, pe, good, ov;
    int n;
    bits.push_back(1'b1);
    for (int i = 0; i < 8; i++) bits.push_back(w[i]);
    if (p == 1) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    n = bits.size();
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        cycle(p, 1'b0, 1'($urandom_range(1)), 1'b0);
        chk("gap.busy", g_busy(p), (k > 0));
        chk("gap.valid", g_valid(p), exp_valid[p]);
      end
      cycle(p, 1'b1, bits[k], (k == n - 1) && ack_stop);
      if (k < n - 1) begin
        chk("bit.busy", g_busy(p), 1'b1);
        chk("bit.pulses", {g_ferr(p), g_perr(p), g_ovr(p)}, 3'b000);
      end
    end
    f    = stop_bit;
    pe   = (p == 1) && ((^w) ^ par_bit);
    good = !f && !pe;
    ov   = good && exp_valid[p] && !ack_stop;
    if (good && !ov) begin
      exp_out[p]   = w;
      exp_valid[p] = 1'b1;
    end else if (ack_stop) begin
      exp_valid[p] = 1'b0;
    end
    chk("stop.frame_err",  g_ferr(p), f);
    chk("stop.parity_err", g_perr(p), pe);
    chk("stop.overrun",    g_ovr(p),  ov);
    chk("stop.busy",       g_busy(p), 1'b0);
    chk_state(p, "stop");
    if (post_idle) begin
      cycle(p, 1'b0, 1'b0, 1'b0);
      chk("post.pulses", {g_ferr(p), g_perr(p), g_ovr(p)}, 3'b000);
      chk("post.busy", g_busy(p), 1'b0);
      chk_state(p, "post");
    end
  endtask

  task automatic do_ack(input int p);
    cycle(p, 1'b0, 1'b0, 1'b1);
    exp_valid[p] = 1'b0;
    chk_state(p, "ack");
  endtask

  task automatic chk_all_zero(input string tag);
    for (int p = 0; p < 2; p++) begin
      chk({tag, ".data"},   g_out(p),   8'h00);
      chk({tag, ".outs"},   {g_valid(p), g_ferr(p), g_perr(p), g_ovr(p), g_busy(p)}, 5'b0);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic       pb;
    int         p;
    for (int i = 0; i < 2; i++) begin exp_out[i] = 8'h00; exp_valid[i] = 1'b0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, then ack
    send_frame(0, 8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    do_ack(0);
    // Ack while nothing is held is ignored
    do_ack(0);

    // Gapped enable
    send_frame(0, 8'hA5, 1'b0, 1'b0, 3, 1'b0, 1'b1);
    do_ack(0);

    // Stop-bit error followed by a good frame
    send_frame(0, 8'h3C, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    do_ack(0);

    // Overrun, then simultaneous ack on the stop edge
    send_frame(0, 8'h11, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    do_ack(0);

    // Parity: correct, wrong, and wrong together with a bad stop bit
    send_frame(1, 8'h07, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    do_ack(1);
    send_frame(1, 8'h07, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    send_frame(1, 8'h07, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    send_frame(1, 8'hF0, 1'b0, 1'b0, 1, 1'b0, 1'b1);

    // Random frames, including back-to-back starts and random acks
    for (int it = 0; it < 40; it++) begin
      p  = int'($urandom_range(1));
      w  = 8'($urandom);
      pb = (^w) ^ ($urandom_range(5) == 0);
      send_frame(p, w, pb, ($urandom_range(7) == 0), int'($urandom_range(2)),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
      if ($urandom_range(3) == 0) do_ack(p);
    end

    // Reset mid-frame: start bit plus four data bits, then async reset
    if (exp_valid[0]) do_ack(0);
    cycle(0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(0, 1'b1, 1'($urandom_range(1)), 1'b0);
    chk("mid.busy", g_busy(0), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int i = 0; i < 2; i++) begin exp_out[i] = 8'h00; exp_valid[i] = 1'b0; end
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
